mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps the select lines of an external 4:1 mux over the
// enabled channels, waits dwell+1 cycles on each, samples the mux output
// and presents the assembled word as a frame with a valid/ready handshake.
//
// state  | meaning
// IDLE   | S parked at 0, waiting for en with a non-empty channel mask
// SETTLE | S on one channel, counting settle cycles, sampling Y_in at the end
// HOLD   | frame valid, waiting for the consumer to accept it
module mux_scan_ctrl #(
  parameter int DW_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [3:0]      chan_mask,
  input  logic [DW_W-1:0] dwell,
  output logic [1:0]      S,
  input  logic            Y_in,
  output logic [3:0]      frame,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic            busy,
  output logic [7:0]      frame_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      mask_q, mask_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [DW_W-1:0] cnt_q, cnt_d;
  logic [3:0]      shadow_q, shadow_d;
  logic [1:0]      s_q, s_d;
  logic [3:0]      frame_q, frame_d;
  logic            fv_q, fv_d;
  logic            busy_q, busy_d;
  logic [7:0]      fcnt_q, fcnt_d;

  logic            start_ok;
  logic            do_start;
  logic [3:0]      sample;
  logic [2:0]      nxt;

  // Index of the lowest set bit (mask assumed non-zero by the caller).
  function automatic logic [1:0] low_bit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = i[1:0];
    end
    return r;
  endfunction

  // {found, index} of the next set bit strictly above s.
  function automatic logic [2:0] next_bit(input logic [3:0] m, input logic [1:0] s);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(s))) r = {1'b1, i[1:0]};
    end
    return r;
  endfunction

  // Next-state and next-output computation for the scan sequencer.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    s_d      = s_q;
    frame_d  = frame_q;
    fv_d     = fv_q;
    fcnt_d   = fcnt_q;
    do_start = 1'b0;
    start_ok = en && (chan_mask != 4'b0000);
    sample   = shadow_q;
    sample[s_q] = Y_in;
    nxt      = next_bit(mask_q, s_q);

    case (state_q)
      IDLE: begin
        s_d  = 2'd0;
        fv_d = 1'b0;
        if (start_ok) do_start = 1'b1;
      end
      SETTLE: begin
        if (!en) begin
          // abort drops the partial scan; frame and frame_cnt untouched
          state_d  = IDLE;
          s_d      = 2'd0;
          cnt_d    = '0;
          shadow_d = 4'b0000;
        end else if (cnt_q == dwell_q) begin
          if (nxt[2]) begin
            shadow_d = sample;
            s_d      = nxt[1:0];
            cnt_d    = '0;
          end else begin
            shadow_d = sample;
            frame_d  = sample;
            fv_d     = 1'b1;
            state_d  = HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          fcnt_d = fcnt_q + 8'd1;
          fv_d   = 1'b0;
          if (start_ok) begin
            do_start = 1'b1;
          end else begin
            state_d = IDLE;
            s_d     = 2'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 2'd0;
        fv_d    = 1'b0;
      end
    endcase

    if (do_start) begin
      state_d  = SETTLE;
      mask_d   = chan_mask;
      dwell_d  = dwell;
      s_d      = low_bit(chan_mask);
      cnt_d    = '0;
      shadow_d = 4'b0000;
      fv_d     = 1'b0;
    end

    busy_d = (state_d == SETTLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= 4'b0000;
      dwell_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= 4'b0000;
      s_q      <= 2'd0;
      frame_q  <= 4'b0000;
      fv_q     <= 1'b0;
      busy_q   <= 1'b0;
      fcnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      s_q      <= s_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
      busy_q   <= busy_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign S           = s_q;
  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;
  assign frame_cnt   = fcnt_q;

endmodule
